// File: rtl/fifo_ctrl_sync.sv
// fifo_ctrl_sync: single-clock FIFO controller sequencing one fifomem (DSIZE x 2^ASIZE,
// registered read port). Upstream data goes straight to mem wdata; downstream sees show-ahead
// data directly from mem rdata, so the memory read register acts as the output stage.
// Total capacity is DEPTH+1 words (DEPTH in the array plus one in the rdata register).
//
// Ports:
//   clk, rst_n            clock (posedge) and asynchronous active-low reset
//   s_valid / s_ready     upstream handshake; a write happens when both are high
//   m_valid / m_ready     downstream handshake; head word taken when both are high
//   m_data                head word, wired from mem_rdata
//   mem_rdata             fifomem read data
//   mem_waddr/mem_wclken  fifomem write address / write clock enable
//   mem_raddr/mem_rclken  fifomem read address / read clock enable
//   level, almost_full    occupancy outputs, present only with FIFO_LEVEL_EN defined
//
// Optional feature macro: FIFO_LEVEL_EN (adds registered level and almost_full outputs).

module fifo_ctrl_sync #(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned ASIZE     = 4,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic [ASIZE-1:0] mem_waddr,
  output logic             mem_wclken,
  output logic [ASIZE-1:0] mem_raddr,
  output logic             mem_rclken
`ifdef FIFO_LEVEL_EN
  ,
  output logic [ASIZE:0]   level,
  output logic             almost_full
`endif
);

  localparam int unsigned    DEPTH    = 1 << ASIZE;
  localparam logic [ASIZE:0] DepthCnt = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] PtrOne   = (ASIZE+1)'(1);

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } out_state_e;

  logic [ASIZE:0] r_wptr;
  logic [ASIZE:0] r_rptr;
  out_state_e     r_state;
  out_state_e     w_state_nxt;

  logic [ASIZE:0] w_mem_cnt;
  logic           w_full;
  logic           w_wr;
  logic           w_rd;

  // Words in the array not yet issued to the read port; the extra pointer MSB
  // separates full (DEPTH) from empty (0).
  assign w_mem_cnt = r_wptr - r_rptr;
  assign w_full    = (w_mem_cnt == DepthCnt);

  assign s_ready = ~w_full;
  assign m_valid = (r_state == StFull);
  assign m_data  = mem_rdata;

  // Gated by rst_n so both memory enables drop the instant reset asserts.
  assign w_wr = s_valid & s_ready & rst_n;
  assign w_rd = (w_mem_cnt != '0) & (~m_valid | m_ready) & rst_n;

  assign mem_wclken = w_wr;
  assign mem_waddr  = r_wptr[ASIZE-1:0];
  assign mem_rclken = w_rd;
  assign mem_raddr  = r_rptr[ASIZE-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PtrOne;
      if (w_rd) r_rptr <= r_rptr + PtrOne;
    end
  end

  // Output stage: StFull means the rdata register holds an unconsumed head word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StEmpty: if (w_rd) w_state_nxt = StFull;
      // While stalled rclken stays low, so rdata (and m_data) hold.
      StFull:  if (m_ready && !w_rd) w_state_nxt = StEmpty;
      default: w_state_nxt = StEmpty;
    endcase
  end

`ifdef FIFO_LEVEL_EN
  localparam logic [ASIZE:0] AfullLvl = (ASIZE+1)'(AFULL_LVL);

  logic [ASIZE:0] r_level;
  logic           r_almost_full;
  logic [ASIZE:0] w_level;

  assign w_level = w_mem_cnt + {{ASIZE{1'b0}}, m_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      r_level       <= w_level;
      r_almost_full <= (w_level >= AfullLvl);
    end
  end

  assign level       = r_level;
  assign almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// Self-checking bench for fifo_ctrl_sync with a behavioural fifomem (registered read).
// Inputs are driven 1 ns after posedge; outputs and handshakes are sampled on negedge.
module tb_fifo_ctrl_sync;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic [7:0] mem_rdata;
  logic [3:0] mem_waddr;
  logic       mem_wclken;
  logic [3:0] mem_raddr;
  logic       mem_rclken;
  logic [7:0] s_data = 8'h00;
`ifdef FIFO_LEVEL_EN
  logic [4:0] level;
  logic       almost_full;
`endif

  always #5 clk = ~clk;

  fifo_ctrl_sync #(.DSIZE(8), .ASIZE(4), .AFULL_LVL(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .mem_rdata  (mem_rdata),
    .mem_waddr  (mem_waddr),
    .mem_wclken (mem_wclken),
    .mem_raddr  (mem_raddr),
    .mem_rclken (mem_rclken)
`ifdef FIFO_LEVEL_EN
    ,
    .level      (level),
    .almost_full(almost_full)
`endif
  );

  // fifomem model
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (mem_wclken) mem[mem_waddr] <= s_data;
    if (mem_rclken) mem_rdata <= mem[mem_raddr];
  end

  int n_checks = 0;
  int n_errors = 0;
  int rx_cnt = 0;
  logic [7:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on accepted write, pop and compare on accepted read.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_valid && s_ready) sb.push_back(s_data);
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pop_empty: got 0x%0h expected no word at %0t", m_data, $time);
        end else begin
          check("m_data", {24'h0, m_data}, {24'h0, sb.pop_front()});
          rx_cnt++;
        end
      end
    end
  end

  typedef struct {
    logic       sv;
    logic       mr;
    logic [7:0] d;
    logic       e_srdy;
    logic       e_wclk;
    logic       e_rclk;
    logic       e_mv;
    logic [3:0] e_wa;
    logic [3:0] e_ra;
  } vec_t;

  function automatic vec_t mk(input logic sv, input logic mr, input logic [7:0] d,
                              input logic srdy, input logic wclk, input logic rclk,
                              input logic mv, input logic [3:0] wa, input logic [3:0] ra);
    vec_t v;
    v.sv = sv; v.mr = mr; v.d = d; v.e_srdy = srdy; v.e_wclk = wclk;
    v.e_rclk = rclk; v.e_mv = mv; v.e_wa = wa; v.e_ra = ra;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      cyc();
      if (sb.size() == 0 && !m_valid) done = 1'b1;
    end
    check({name, "_drained"}, {31'h0, done}, 32'h1);
  endtask

  task automatic wait_mvalid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    check({name, "_mvalid_timeout"}, {31'h0, seen}, 32'h1);
  endtask

  vec_t vt [10];

  initial begin
    int rx0;
    bit acc;
    int sent;
    bit done;

    // Single word, then back-to-back pair with a one-cycle stall, from reset.
    vt[0] = mk(1, 1, 8'hA5, 1, 1, 0, 0, 4'd0, 4'd0);
    vt[1] = mk(0, 1, 8'h00, 1, 0, 1, 0, 4'd1, 4'd0);
    vt[2] = mk(0, 1, 8'h00, 1, 0, 0, 1, 4'd1, 4'd1);
    vt[3] = mk(0, 1, 8'h00, 1, 0, 0, 0, 4'd1, 4'd1);
    vt[4] = mk(1, 1, 8'h11, 1, 1, 0, 0, 4'd1, 4'd1);
    vt[5] = mk(1, 1, 8'h22, 1, 1, 1, 0, 4'd2, 4'd1);
    vt[6] = mk(0, 0, 8'h00, 1, 0, 0, 1, 4'd3, 4'd2);
    vt[7] = mk(0, 1, 8'h00, 1, 0, 1, 1, 4'd3, 4'd2);
    vt[8] = mk(0, 1, 8'h00, 1, 0, 0, 1, 4'd3, 4'd3);
    vt[9] = mk(0, 0, 8'h00, 1, 0, 0, 0, 4'd3, 4'd3);

    // Reset values while held in reset
    #3;
    check("rst_m_valid", {31'h0, m_valid}, 32'h0);
    check("rst_s_ready", {31'h0, s_ready}, 32'h1);
    check("rst_wclken", {31'h0, mem_wclken}, 32'h0);
    check("rst_rclken", {31'h0, mem_rclken}, 32'h0);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      s_valid = vt[i].sv;
      m_ready = vt[i].mr;
      s_data  = vt[i].d;
      @(negedge clk);
      check($sformatf("vec%0d_s_ready", i), {31'h0, s_ready}, {31'h0, vt[i].e_srdy});
      check($sformatf("vec%0d_wclken", i), {31'h0, mem_wclken}, {31'h0, vt[i].e_wclk});
      check($sformatf("vec%0d_rclken", i), {31'h0, mem_rclken}, {31'h0, vt[i].e_rclk});
      check($sformatf("vec%0d_m_valid", i), {31'h0, m_valid}, {31'h0, vt[i].e_mv});
      check($sformatf("vec%0d_waddr", i), {28'h0, mem_waddr}, {28'h0, vt[i].e_wa});
      check($sformatf("vec%0d_raddr", i), {28'h0, mem_raddr}, {28'h0, vt[i].e_ra});
      cyc();
    end
    check("vec_rx_count", rx_cnt, 3);

    // Reset asserted mid-stream
    s_valid = 1'b1;
    m_ready = 1'b1;
    s_data = 8'h70;
    for (int i = 0; i < 6; i++) begin
      cyc();
      s_data = s_data + 8'h01;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", {31'h0, m_valid}, 32'h0);
    check("midrst_s_ready", {31'h0, s_ready}, 32'h1);
    check("midrst_wclken", {31'h0, mem_wclken}, 32'h0);
    check("midrst_rclken", {31'h0, mem_rclken}, 32'h0);
    check("midrst_waddr", {28'h0, mem_waddr}, 32'h0);
    check("midrst_raddr", {28'h0, mem_raddr}, 32'h0);
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
    cyc();
    rx0 = rx_cnt;
    s_valid = 1'b1;
    s_data = 8'h5A;
    cyc();
    s_data = 8'h5B;
    cyc();
    drain("midrst");
    check("midrst_rx_count", rx_cnt - rx0, 2);

    // Fill to DEPTH+1 with the output stalled
    rx0 = rx_cnt;
    m_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      s_valid = 1'b1;
      s_data = 8'(i);
      cyc();
    end
    s_data = 8'hEE;
    @(negedge clk);
    check("fill_s_ready_full", {31'h0, s_ready}, 32'h0);
    check("fill_wclken_ignored", {31'h0, mem_wclken}, 32'h0);
    cyc();
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("fill_s_ready_first_pop", {31'h0, s_ready}, 32'h0);
    cyc();
    @(negedge clk);
    check("fill_s_ready_after_pop", {31'h0, s_ready}, 32'h1);
    drain("fill");
    check("fill_rx_count", rx_cnt - rx0, 17);

    // Stall hold with a word waiting in memory
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h3C;
    cyc();
    s_data = 8'h3D;
    cyc();
    s_valid = 1'b0;
    wait_mvalid("stall");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_m_data", i), {24'h0, m_data}, 32'h3C);
      check($sformatf("stall%0d_rclken", i), {31'h0, mem_rclken}, 32'h0);
      @(negedge clk);
    end
    #6;
    drain("stall");

    // Streaming with random backpressure; 72 words wrap both pointers twice
    rx0 = rx_cnt;
    sent = 0;
    done = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h00;
    for (int i = 0; i < 1000 && !done; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = s_valid & s_ready;
      cyc();
      if (acc) begin
        sent++;
        s_data = s_data + 8'h01;
        if (sent == 72) s_valid = 1'b0;
      end
      if (sent == 72 && sb.size() == 0 && !m_valid) done = 1'b1;
    end
    check("stream_done", {31'h0, done}, 32'h1);
    check("stream_rx_count", rx_cnt - rx0, 72);

`ifdef FIFO_LEVEL_EN
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1;
      s_data = 8'(8'h80 + i);
      cyc();
    end
    s_valid = 1'b0;
    repeat (2) cyc();
    check("lvl_level12", {27'h0, level}, 32'd12);
    check("lvl_afull12", {31'h0, almost_full}, 32'h1);
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    repeat (2) cyc();
    check("lvl_level11", {27'h0, level}, 32'd11);
    check("lvl_afull11", {31'h0, almost_full}, 32'h0);
    drain("lvl");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
